// File: rtl/spr_file.sv
`default_nettype none
// ============================================================================
//  Module      : spr_file
//  Description : Architectural special-purpose register file holding XER (1),
//                LR (8) and CTR (9), each with a 32-bit value, a pending bit
//                and a rename tag.
//                - Dispatch read port (combinational) with writeback bypass.
//                - Dispatch tag-reservation port and global flush of pending.
//                - Writeback port from the system unit (never stalls).
//                - Registered one-cycle operand-update broadcast per write.
//                - illegal_spr pulse for any access to an unimplemented SPR.
//  Ports       : clk/rst (async active-high), rd_*, reserve_*, flush,
//                spr_* writeback channel, update_spr_op_* broadcast,
//                illegal_spr.
//  Revision    : 1.0 - initial release
// ============================================================================
module spr_file #(
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    // dispatch read port
    input  logic [9:0]             rd_addr,
    output logic [31:0]            rd_value,
    output logic                   rd_valid,
    output logic [RS_ID_WIDTH-1:0] rd_rs_id,
    // dispatch reservation port
    input  logic                   reserve_valid,
    input  logic [9:0]             reserve_addr,
    input  logic [RS_ID_WIDTH-1:0] reserve_rs_id,
    input  logic                   flush,
    // writeback channel from the system unit
    input  logic                   spr_output_valid,
    output logic                   spr_output_ready,
    input  logic [RS_ID_WIDTH-1:0] spr_rs_id_out,
    input  logic [9:0]             spr_result_reg_addr_out,
    input  logic [31:0]            spr_result,
    // operand-update broadcast to the reservation stations
    output logic                   update_spr_op_valid,
    output logic [RS_ID_WIDTH-1:0] update_spr_op_rs_id_in,
    output logic [31:0]            update_spr_op_value_in,
    output logic                   illegal_spr
);

    localparam int         c_NUM_SPR  = 3;
    localparam logic [1:0] c_IDX_NONE = 2'd3;

    // Map an SPR number onto a storage slot; c_IDX_NONE for unimplemented.
    function automatic logic [1:0] spr_index(input logic [9:0] addr);
        logic [1:0] idx;
        case (addr)
            10'd1:   idx = 2'd0;   // XER
            10'd8:   idx = 2'd1;   // LR
            10'd9:   idx = 2'd2;   // CTR
            default: idx = c_IDX_NONE;
        endcase
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]            value_q   [c_NUM_SPR];
    logic [31:0]            value_d   [c_NUM_SPR];
    logic [RS_ID_WIDTH-1:0] tag_q     [c_NUM_SPR];
    logic [RS_ID_WIDTH-1:0] tag_d     [c_NUM_SPR];
    logic [c_NUM_SPR-1:0]   pending_q;
    logic [c_NUM_SPR-1:0]   pending_d;

    logic                   ready_q;
    logic                   upd_valid_q;
    logic                   upd_valid_d;
    logic [RS_ID_WIDTH-1:0] upd_tag_q;
    logic [RS_ID_WIDTH-1:0] upd_tag_d;
    logic [31:0]            upd_value_q;
    logic [31:0]            upd_value_d;
    logic                   illegal_q;
    logic                   illegal_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [1:0] w_rd_idx;
    logic [1:0] w_rsv_idx;
    logic [1:0] w_wr_idx;
    logic       w_wr_fire;

    assign w_rd_idx  = spr_index(rd_addr);
    assign w_rsv_idx = spr_index(reserve_addr);
    assign w_wr_idx  = spr_index(spr_result_reg_addr_out);
    assign w_wr_fire = spr_output_valid & ready_q;

    // ------------------------------------------------------------------
    // Read port. A pending register whose producer is writing back this
    // very cycle is forwarded straight from the writeback data so dispatch
    // does not miss the broadcast that is about to go out.
    // ------------------------------------------------------------------
    always_comb begin
        rd_value = 32'd0;
        rd_valid = 1'b1;
        rd_rs_id = '0;
        if (w_rd_idx != c_IDX_NONE) begin
            rd_value = value_q[w_rd_idx];
            if (pending_q[w_rd_idx]) begin
                if (w_wr_fire && (w_wr_idx == w_rd_idx) &&
                    (spr_rs_id_out == tag_q[w_rd_idx])) begin
                    rd_value = spr_result;
                end else begin
                    rd_valid = 1'b0;
                    rd_rs_id = tag_q[w_rd_idx];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state. Priority per register, lowest to highest:
    // writeback clear (matching tag only) / flush clear, then reserve.
    // The writeback tag match uses the pre-update tag.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < c_NUM_SPR; i++) begin
            value_d[i]   = value_q[i];
            tag_d[i]     = tag_q[i];
            pending_d[i] = pending_q[i];

            if (w_wr_fire && (w_wr_idx == i[1:0])) begin
                value_d[i] = spr_result;
                if (pending_q[i] && (tag_q[i] == spr_rs_id_out)) begin
                    pending_d[i] = 1'b0;
                end
            end

            if (flush) begin
                pending_d[i] = 1'b0;
            end

            if (reserve_valid && (w_rsv_idx == i[1:0])) begin
                pending_d[i] = 1'b1;
                tag_d[i]     = reserve_rs_id;
            end
        end
    end

    // Broadcast payload holds its last value between strobes.
    always_comb begin
        upd_valid_d = w_wr_fire && (w_wr_idx != c_IDX_NONE);
        upd_tag_d   = upd_tag_q;
        upd_value_d = upd_value_q;
        if (upd_valid_d) begin
            upd_tag_d   = spr_rs_id_out;
            upd_value_d = spr_result;
        end
    end

    // The read port is always active, so an unimplemented rd_addr on its
    // own is enough to raise the flag.
    always_comb begin
        illegal_d = (w_rd_idx == c_IDX_NONE) ||
                    (reserve_valid && (w_rsv_idx == c_IDX_NONE)) ||
                    (w_wr_fire && (w_wr_idx == c_IDX_NONE));
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_SPR; i++) begin
                value_q[i] <= 32'd0;
                tag_q[i]   <= '0;
            end
            pending_q   <= '0;
            ready_q     <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_tag_q   <= '0;
            upd_value_q <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            for (int i = 0; i < c_NUM_SPR; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
            pending_q   <= pending_d;
            ready_q     <= 1'b1;
            upd_valid_q <= upd_valid_d;
            upd_tag_q   <= upd_tag_d;
            upd_value_q <= upd_value_d;
            illegal_q   <= illegal_d;
        end
    end

    assign spr_output_ready       = ready_q;
    assign update_spr_op_valid    = upd_valid_q;
    assign update_spr_op_rs_id_in = upd_tag_q;
    assign update_spr_op_value_in = upd_value_q;
    assign illegal_spr            = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_spr_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spr_file
//  Description : Directed self-checking bench for spr_file. Inputs change
//                1 time unit after a rising edge; outputs are sampled either
//                1 unit after an edge (registered) or 1 unit after an input
//                change (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spr_file;

    localparam int RS_ID_WIDTH = 5;

    logic                   clk;
    logic                   rst;
    logic [9:0]             rd_addr;
    logic [31:0]            rd_value;
    logic                   rd_valid;
    logic [RS_ID_WIDTH-1:0] rd_rs_id;
    logic                   reserve_valid;
    logic [9:0]             reserve_addr;
    logic [RS_ID_WIDTH-1:0] reserve_rs_id;
    logic                   flush;
    logic                   spr_output_valid;
    logic                   spr_output_ready;
    logic [RS_ID_WIDTH-1:0] spr_rs_id_out;
    logic [9:0]             spr_result_reg_addr_out;
    logic [31:0]            spr_result;
    logic                   update_spr_op_valid;
    logic [RS_ID_WIDTH-1:0] update_spr_op_rs_id_in;
    logic [31:0]            update_spr_op_value_in;
    logic                   illegal_spr;

    int n_cmp  = 0;
    int n_fail = 0;

    spr_file #(.RS_ID_WIDTH(RS_ID_WIDTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rd_addr                (rd_addr),
        .rd_value               (rd_value),
        .rd_valid               (rd_valid),
        .rd_rs_id               (rd_rs_id),
        .reserve_valid          (reserve_valid),
        .reserve_addr           (reserve_addr),
        .reserve_rs_id          (reserve_rs_id),
        .flush                  (flush),
        .spr_output_valid       (spr_output_valid),
        .spr_output_ready       (spr_output_ready),
        .spr_rs_id_out          (spr_rs_id_out),
        .spr_result_reg_addr_out(spr_result_reg_addr_out),
        .spr_result             (spr_result),
        .update_spr_op_valid    (update_spr_op_valid),
        .update_spr_op_rs_id_in (update_spr_op_rs_id_in),
        .update_spr_op_value_in (update_spr_op_value_in),
        .illegal_spr            (illegal_spr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_read(input string tag, input logic [9:0] addr,
                              input logic vld, input logic [31:0] val,
                              input logic [RS_ID_WIDTH-1:0] id);
        rd_addr = addr;
        settle();
        check({tag, ".valid"}, 32'(rd_valid), 32'(vld));
        check({tag, ".value"}, rd_value, val);
        check({tag, ".rs_id"}, 32'(rd_rs_id), 32'(id));
    endtask

    task automatic check_bcast(input string tag, input logic vld,
                               input logic [RS_ID_WIDTH-1:0] id, input logic [31:0] val);
        check({tag, ".valid"}, 32'(update_spr_op_valid), 32'(vld));
        if (vld) begin
            check({tag, ".tag"}, 32'(update_spr_op_rs_id_in), 32'(id));
            check({tag, ".value"}, update_spr_op_value_in, val);
        end
    endtask

    task automatic wb(input logic v, input logic [9:0] addr,
                      input logic [RS_ID_WIDTH-1:0] id, input logic [31:0] val);
        spr_output_valid        = v;
        spr_result_reg_addr_out = addr;
        spr_rs_id_out           = id;
        spr_result              = val;
    endtask

    task automatic rsv(input logic v, input logic [9:0] addr, input logic [RS_ID_WIDTH-1:0] id);
        reserve_valid = v;
        reserve_addr  = addr;
        reserve_rs_id = id;
    endtask

    // Guard against any unexpected stall of the stimulus thread.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b0;
        rd_addr = 10'd8;
        rsv(1'b0, 10'd0, '0);
        flush = 1'b0;
        wb(1'b0, 10'd0, '0, 32'd0);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        check("rst.ready",   32'(spr_output_ready), 32'd0);
        check("rst.illegal", 32'(illegal_spr), 32'd0);
        check("rst.upd_tag", 32'(update_spr_op_rs_id_in), 32'd0);
        check("rst.upd_val", update_spr_op_value_in, 32'd0);
        check("rst.upd_vld", 32'(update_spr_op_valid), 32'd0);
        #2 rst = 1'b0;
        step();
        check("ready_after_rst", 32'(spr_output_ready), 32'd1);

        // ---------------- read after reset, unimplemented read ----------------
        check_read("rd_lr0",  10'd8, 1'b1, 32'd0, '0);
        check_read("rd_ctr0", 10'd9, 1'b1, 32'd0, '0);
        check_read("rd_xer0", 10'd1, 1'b1, 32'd0, '0);
        check_read("rd_3ff",  10'h3FF, 1'b1, 32'd0, '0);
        check("illegal_same_cycle", 32'(illegal_spr), 32'd0);
        step();
        rd_addr = 10'd8;
        check("illegal_pulse", 32'(illegal_spr), 32'd1);
        step();
        check("illegal_clear", 32'(illegal_spr), 32'd0);

        // ---------------- reserve LR, writeback with bypass ----------------
        rsv(1'b1, 10'd8, 5'd3);
        step();
        rsv(1'b0, 10'd0, '0);
        check_read("lr_pend", 10'd8, 1'b0, 32'd0, 5'd3);
        wb(1'b1, 10'd8, 5'd3, 32'hDEADBEEF);
        check_read("lr_bypass", 10'd8, 1'b1, 32'hDEADBEEF, '0);
        step();
        wb(1'b0, 10'd0, '0, 32'd0);
        check_bcast("bc_lr", 1'b1, 5'd3, 32'hDEADBEEF);
        check_read("lr_done", 10'd8, 1'b1, 32'hDEADBEEF, '0);
        step();
        check_bcast("bc_lr_once", 1'b0, '0, 32'd0);

        // ---------------- CTR: older producer does not clear pending ----------------
        rsv(1'b1, 10'd9, 5'd4);
        step();
        rsv(1'b1, 10'd9, 5'd7);
        step();
        rsv(1'b0, 10'd0, '0);
        check_read("ctr_pend7", 10'd9, 1'b0, 32'd0, 5'd7);
        wb(1'b1, 10'd9, 5'd4, 32'd5);
        check_read("ctr_nobypass", 10'd9, 1'b0, 32'd0, 5'd7);
        step();
        wb(1'b0, 10'd0, '0, 32'd0);
        check_bcast("bc_ctr4", 1'b1, 5'd4, 32'd5);
        check_read("ctr_still_pend", 10'd9, 1'b0, 32'd5, 5'd7);
        wb(1'b1, 10'd9, 5'd7, 32'd6);
        step();
        wb(1'b0, 10'd0, '0, 32'd0);
        check_bcast("bc_ctr7", 1'b1, 5'd7, 32'd6);
        check_read("ctr_done", 10'd9, 1'b1, 32'd6, '0);

        // ---------------- XER: reserve + writeback same cycle ----------------
        rsv(1'b1, 10'd1, 5'd1);
        step();
        rsv(1'b1, 10'd1, 5'd2);
        wb(1'b1, 10'd1, 5'd1, 32'h20000000);
        step();
        rsv(1'b0, 10'd0, '0);
        wb(1'b0, 10'd0, '0, 32'd0);
        check_read("xer_rsv_wb", 10'd1, 1'b0, 32'h20000000, 5'd2);

        // ---------------- flush ----------------
        rsv(1'b1, 10'd8, 5'd9);
        step();
        rsv(1'b1, 10'd9, 5'd10);
        step();
        rsv(1'b0, 10'd0, '0);
        check_read("lr_pend9",   10'd8, 1'b0, 32'hDEADBEEF, 5'd9);
        check_read("ctr_pend10", 10'd9, 1'b0, 32'd6, 5'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_read("lr_flushed",  10'd8, 1'b1, 32'hDEADBEEF, '0);
        check_read("ctr_flushed", 10'd9, 1'b1, 32'd6, '0);
        check_read("xer_flushed", 10'd1, 1'b1, 32'h20000000, '0);
        flush = 1'b1;
        rsv(1'b1, 10'd8, 5'd11);
        step();
        flush = 1'b0;
        rsv(1'b0, 10'd0, '0);
        check_read("lr_flush_rsv", 10'd8, 1'b0, 32'hDEADBEEF, 5'd11);

        // ---------------- writeback to unimplemented SPR ----------------
        wb(1'b1, 10'd5, 5'd1, 32'h0000FFFF);
        step();
        wb(1'b0, 10'd0, '0, 32'd0);
        check("illegal_wb", 32'(illegal_spr), 32'd1);
        check_bcast("bc_unimpl", 1'b0, '0, 32'd0);

        // ---------------- back-to-back broadcasts, then reset mid-stream ----------------
        wb(1'b1, 10'd8, 5'd11, 32'h11111111);
        step();
        check_bcast("bc_seq0", 1'b1, 5'd11, 32'h11111111);
        wb(1'b1, 10'd9, 5'd0, 32'h22222222);
        step();
        check_bcast("bc_seq1", 1'b1, 5'd0, 32'h22222222);
        wb(1'b1, 10'd1, 5'd0, 32'h33333333);
        step();
        check_bcast("bc_seq2", 1'b1, 5'd0, 32'h33333333);
        wb(1'b1, 10'd8, 5'd5, 32'h44444444);
        #2 rst = 1'b1;
        settle();
        check("midrst.upd_vld", 32'(update_spr_op_valid), 32'd0);
        check("midrst.upd_tag", 32'(update_spr_op_rs_id_in), 32'd0);
        check("midrst.upd_val", update_spr_op_value_in, 32'd0);
        check("midrst.ready",   32'(spr_output_ready), 32'd0);
        check_read("midrst_lr", 10'd8, 1'b1, 32'd0, '0);
        step();
        wb(1'b0, 10'd0, '0, 32'd0);
        #2 rst = 1'b0;
        step();
        check_bcast("post_rst0", 1'b0, '0, 32'd0);
        step();
        check_bcast("post_rst1", 1'b0, '0, 32'd0);
        check_read("post_rst_xer", 10'd1, 1'b1, 32'd0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
